magia_eoc_collector: RTL and testbench
======================================

# magia_eoc_collector

Multi-tile run controller and end-of-computation (EOC) collector for MAGIA mesh simulation and bring-up. After a start pulse it raises fetch-enable to N tiles and tracks each tile's EOC and exit code. It then reports one aggregate verdict: all done, first failing tile, or watchdog timeout. It sits between the testbench/VIP layer and the tile array and replaces per-tile `wait_for_eoc` polling with one synthesizable, cycle-exact monitor.

## Interface
- `N_TILES`, default 4: number of monitored tiles, at least 1.
- `EXIT_W`, default 32: exit-code width.
- `TMO_W`, default 32: watchdog counter width.
- `ID_W`, default `$clog2(N_TILES)` (1 if `N_TILES`==1): tile-index width.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `start_i`  in  1  single-cycle run request
- `clear_i`  in  1  abort/clear back to IDLE
- `timeout_cycles_i`  in  TMO_W  watchdog limit in RUN cycles; 0 disables the watchdog
- `tile_eoc_i`  in  N_TILES  per-tile EOC level
- `tile_exit_code_i`  in  N_TILES x EXIT_W  per-tile exit code, valid while the matching EOC is high
- `fetch_en_o`  out  N_TILES  per-tile fetch enable
- `busy_o`  out  1  high in RUN
- `done_o`  out  1  high in DONE
- `exit_code_o`  out  EXIT_W  aggregate exit code
- `eoc_mask_o`  out  N_TILES  sticky per-tile EOC seen
- `fail_mask_o`  out  N_TILES  sticky per-tile nonzero exit
- `first_fail_id_o`  out  ID_W  index of the first failing tile
- `first_fail_vld_o`  out  1  `first_fail_id_o` is valid
- `timeout_o`  out  1  DONE was reached by the watchdog

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, on `start_i`: go to RUN. Clear the masks, counter and first-fail fields.
- RUN, per tile:
  - On the first cycle `tile_eoc_i[i]` is high, set `eoc_mask[i]` and capture that tile's exit code.
  - If the captured code is nonzero, set `fail_mask[i]`.
  - Later EOC or code changes for that tile are ignored.
- First fail:
  - The first cycle any fail bit is newly set fixes `first_fail_id` and sets `first_fail_vld`.
  - Among simultaneous fails, the lowest index wins.
  - Once fixed, the value never changes until the next start or clear.
- RUN to DONE on completion: when all `eoc_mask` bits are set, counting this cycle's captures.
  - `exit_code_o` = 0 if no fail.
  - Otherwise `exit_code_o` = the captured code of `first_fail_id`.
- RUN to DONE on timeout (watchdog enabled only): when `timeout_cycles_i`≠0 and the counter has reached `timeout_cycles_i`.
  - Set `timeout_o`=1 and `exit_code_o`=all-ones.
  - Completion and timeout in the same cycle: completion wins and `timeout_o` stays 0.
- DONE holds every output until `clear_i`; DONE to IDLE on `clear_i`.
- `clear_i` in RUN aborts to IDLE. `clear_i` has priority over `start_i` in the same cycle.
- `start_i` is ignored in RUN and DONE.
- `fetch_en_o` = all-ones in RUN, 0 elsewhere.
- `timeout_cycles_i` is sampled once at start and held for the run.

## Timing
- Reset values: state IDLE. Every output is 0: `fetch_en_o`, `busy_o`, `done_o`, `exit_code_o`, `eoc_mask_o`, `fail_mask_o`, `first_fail_id_o`, `first_fail_vld_o`, `timeout_o`.
- All outputs are registered; there is no combinational input-to-output path.
- `start_i` high at edge k: `busy_o` and `fetch_en_o` are high from edge k on, i.e. one cycle of latency.
- The watchdog counter is 0 at RUN entry, increments every RUN cycle and saturates at its maximum.
- The final EOC sampled at edge k: `done_o` is high, with masks and exit code final, after edge k.
- A timeout with limit T: `done_o` rises T+1 edges after the start edge.
- Reset asserted mid-run: the block returns to reset values immediately and asynchronously.

## Configuration
- `MAGIA_EOC_TIMEOUT_EN` defined: the watchdog counter, `timeout_cycles_i` sampling and the timeout transition are present.
- Not defined: the counter logic is removed, `timeout_cycles_i` is ignored, `timeout_o` is tied to 0, and RUN exits only on completion or clear.

## Structure
- Package `magia_eoc_pkg` holds:
  - the state enum `eoc_state_e` (IDLE/RUN/DONE);
  - the constant `EOC_EXIT_TIMEOUT` (all-ones);
  - a function for lowest-set-bit index.
- Sub-module `magia_eoc_slot` is instantiated N_TILES times. Each slot handles one tile's sticky EOC capture, exit-code register and fail bit, with first-capture enable and clear.
- The top level holds the FSM, watchdog, first-fail arbitration and aggregate exit mux.

## Test plan
- N_TILES=4, start, tiles EOC at cycles 10/20/30/40 with codes 0: `done_o` one cycle after cycle 40, `exit_code_o`=0, `fail_mask_o`=0000, `fetch_en_o` back to 0.
- Tiles 1 and 3 EOC simultaneously with codes 5 and 7, then 0 and 2 with code 0: `fail_mask_o`=1010, `first_fail_id_o`=1, `exit_code_o`=5.
- Tile 2 EOC code 9 at cycle 5, then tile 0 code 3 at cycle 8: `first_fail_id_o`=2 and `exit_code_o`=9. A tile-2 code change after capture has no effect.
- Watchdog: `timeout_cycles_i`=50, only 3 tiles finish: `timeout_o`=1, `exit_code_o`=FFFFFFFF, `done_o` 51 edges after start. With the macro undefined, `done_o` stays 0.
- Last EOC in the exact timeout cycle: `timeout_o`=0 and normal exit code.
- Mid-run: `clear_i` together with `start_i` goes to IDLE with outputs 0, and a second `start_i` during RUN is ignored. `rst_ni` low at cycle 15 asynchronously zeroes all outputs.

Source files
------------

// File: rtl/magia_eoc_pkg.sv
// Shared types and helpers for the MAGIA multi-tile EOC collector.
// Supports up to EOC_MAX_W tiles and exit codes up to EOC_MAX_W bits.
package magia_eoc_pkg;

    typedef enum logic [1:0] {
        EOC_IDLE = 2'd0,
        EOC_RUN  = 2'd1,
        EOC_DONE = 2'd2
    } eoc_state_e;

    localparam int unsigned EOC_MAX_W = 64;

    localparam logic [EOC_MAX_W-1:0] EOC_EXIT_TIMEOUT = '1;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int eoc_lowest_set(input logic [EOC_MAX_W-1:0] vec);
        int idx;
        idx = 0;
        for (int i = EOC_MAX_W - 1; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/magia_eoc_slot.sv
// One tile's sticky EOC capture: first EOC while enabled latches the exit
// code and fail bit; later EOC/code activity is ignored until clr_i.
module magia_eoc_slot #(
    parameter int unsigned EXIT_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              eoc_i,
    input  logic [EXIT_W-1:0] code_i,
    output logic              seen_o,
    output logic              fail_o,
    output logic              seen_d_o,
    output logic              fail_d_o,
    output logic [EXIT_W-1:0] code_d_o
);

    logic              seen_q, seen_d;
    logic              fail_q, fail_d;
    logic [EXIT_W-1:0] code_q, code_d;

    always_comb begin
        seen_d = seen_q;
        fail_d = fail_q;
        code_d = code_q;
        if (clr_i) begin
            seen_d = 1'b0;
            fail_d = 1'b0;
            code_d = '0;
        end else if (en_i && eoc_i && !seen_q) begin
            seen_d = 1'b1;
            code_d = code_i;
            fail_d = |code_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seen_q <= 1'b0;
            fail_q <= 1'b0;
            code_q <= '0;
        end else begin
            seen_q <= seen_d;
            fail_q <= fail_d;
            code_q <= code_d;
        end
    end

    assign seen_o   = seen_q;
    assign fail_o   = fail_q;
    assign seen_d_o = seen_d;
    assign fail_d_o = fail_d;
    assign code_d_o = code_d;

endmodule

// File: rtl/magia_eoc_collector.sv
// Multi-tile run controller / EOC collector with one aggregate verdict.
// Define MAGIA_EOC_TIMEOUT_EN to build in the RUN-cycle watchdog.
module magia_eoc_collector
    import magia_eoc_pkg::*;
#(
    parameter int unsigned N_TILES = 4,
    parameter int unsigned EXIT_W  = 32,
    parameter int unsigned TMO_W   = 32,
    parameter int unsigned ID_W    = (N_TILES > 1) ? $clog2(N_TILES) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_i,
    input  logic                           clear_i,
    input  logic [TMO_W-1:0]               timeout_cycles_i,
    input  logic [N_TILES-1:0]             tile_eoc_i,
    input  logic [N_TILES-1:0][EXIT_W-1:0] tile_exit_code_i,
    output logic [N_TILES-1:0]             fetch_en_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [EXIT_W-1:0]              exit_code_o,
    output logic [N_TILES-1:0]             eoc_mask_o,
    output logic [N_TILES-1:0]             fail_mask_o,
    output logic [ID_W-1:0]                first_fail_id_o,
    output logic                           first_fail_vld_o,
    output logic                           timeout_o
);

    eoc_state_e                     state_q, state_d;
    logic [ID_W-1:0]                ff_id_q, ff_id_d, ff_sel;
    logic                           ff_vld_q, ff_vld_d;
    logic [EXIT_W-1:0]              exit_q, exit_d;
    logic                           tmo_q, tmo_d;
    logic                           start_acc, clr_all, run_en, timeout_hit;
    logic [N_TILES-1:0]             seen_d, fail_d;
    logic [N_TILES-1:0][EXIT_W-1:0] code_d;

    assign start_acc = (state_q == EOC_IDLE) && start_i && !clear_i;
    assign clr_all   = clear_i || start_acc;
    assign run_en    = (state_q == EOC_RUN);

    for (genvar i = 0; i < N_TILES; i++) begin : g_slot
        magia_eoc_slot #(.EXIT_W(EXIT_W)) u_slot (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .clr_i    (clr_all),
            .en_i     (run_en),
            .eoc_i    (tile_eoc_i[i]),
            .code_i   (tile_exit_code_i[i]),
            .seen_o   (eoc_mask_o[i]),
            .fail_o   (fail_mask_o[i]),
            .seen_d_o (seen_d[i]),
            .fail_d_o (fail_d[i]),
            .code_d_o (code_d[i])
        );
    end

`ifdef MAGIA_EOC_TIMEOUT_EN
    logic [TMO_W-1:0] cnt_q, cnt_d, lim_q, lim_d;

    // Limit is latched at start so the run is immune to later input changes.
    always_comb begin
        cnt_d = cnt_q;
        lim_d = lim_q;
        if (start_acc) begin
            cnt_d = '0;
            lim_d = timeout_cycles_i;
        end else if (run_en && (cnt_q != '1)) begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            lim_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            lim_q <= lim_d;
        end
    end

    assign timeout_hit = (lim_q != '0) && (cnt_q >= lim_q);
`else
    logic unused_tmo;
    assign unused_tmo  = ^timeout_cycles_i;
    assign timeout_hit = 1'b0;
`endif

    // With no earlier fail, every bit in fail_d is new, so lowest index wins.
    assign ff_sel = ID_W'(eoc_lowest_set(EOC_MAX_W'(fail_d)));

    always_comb begin
        state_d  = state_q;
        ff_id_d  = ff_id_q;
        ff_vld_d = ff_vld_q;
        exit_d   = exit_q;
        tmo_d    = tmo_q;
        if (clr_all) begin
            ff_id_d  = '0;
            ff_vld_d = 1'b0;
            exit_d   = '0;
            tmo_d    = 1'b0;
        end
        case (state_q)
            EOC_IDLE: if (start_acc) state_d = EOC_RUN;
            EOC_RUN: begin
                if (clear_i) begin
                    state_d = EOC_IDLE;
                end else begin
                    if (!ff_vld_q && (|fail_d)) begin
                        ff_vld_d = 1'b1;
                        ff_id_d  = ff_sel;
                    end
                    if (&seen_d) begin
                        state_d = EOC_DONE;
                        exit_d  = ff_vld_d ? code_d[ff_id_d] : '0;
                    end else if (timeout_hit) begin
                        state_d = EOC_DONE;
                        tmo_d   = 1'b1;
                        exit_d  = EXIT_W'(EOC_EXIT_TIMEOUT);
                    end
                end
            end
            EOC_DONE: if (clear_i) state_d = EOC_IDLE;
            default:  state_d = EOC_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= EOC_IDLE;
            ff_id_q  <= '0;
            ff_vld_q <= 1'b0;
            exit_q   <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ff_id_q  <= ff_id_d;
            ff_vld_q <= ff_vld_d;
            exit_q   <= exit_d;
            tmo_q    <= tmo_d;
        end
    end

    assign busy_o           = (state_q == EOC_RUN);
    assign done_o           = (state_q == EOC_DONE);
    assign fetch_en_o       = {N_TILES{busy_o}};
    assign exit_code_o      = exit_q;
    assign first_fail_id_o  = ff_id_q;
    assign first_fail_vld_o = ff_vld_q;
    assign timeout_o        = tmo_q;

endmodule

// File: tb/tb_magia_eoc_collector.sv
// Self-checking bench for magia_eoc_collector: run-level reference model,
// per-cycle compare, plus directed scenarios with hand-computed verdicts.
module tb_magia_eoc_collector;

    localparam int N  = 4;
    localparam int EW = 32;
    localparam int TW = 32;
    localparam int IW = 2;
`ifdef MAGIA_EOC_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   start = 1'b0;
    logic                   clear = 1'b0;
    logic [TW-1:0]          tmo = '0;
    logic [N-1:0]           eoc = '0;
    logic [N-1:0][EW-1:0]   code = '0;
    logic [N-1:0]           fetch_en, eoc_mask, fail_mask;
    logic                   busy, done, ff_vld, timeout;
    logic [EW-1:0]          exit_code;
    logic [IW-1:0]          ff_id;

    magia_eoc_collector #(.N_TILES(N), .EXIT_W(EW), .TMO_W(TW)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .start_i          (start),
        .clear_i          (clear),
        .timeout_cycles_i (tmo),
        .tile_eoc_i       (eoc),
        .tile_exit_code_i (code),
        .fetch_en_o       (fetch_en),
        .busy_o           (busy),
        .done_o           (done),
        .exit_code_o      (exit_code),
        .eoc_mask_o       (eoc_mask),
        .fail_mask_o      (fail_mask),
        .first_fail_id_o  (ff_id),
        .first_fail_vld_o (ff_vld),
        .timeout_o        (timeout)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: 0 idle, 1 run, 2 done.
    int            m_state;
    bit            m_eoc [N];
    bit            m_fail[N];
    logic [EW-1:0] m_code[N];
    int            m_ffid;
    bit            m_ffvld;
    logic [EW-1:0] m_exit;
    bit            m_tmo;
    longint        m_cyc, m_lim;

    function automatic void m_zero();
        for (int i = 0; i < N; i++) begin
            m_eoc[i] = 0; m_fail[i] = 0; m_code[i] = '0;
        end
        m_ffid = 0; m_ffvld = 0; m_exit = '0; m_tmo = 0;
    endfunction

    function automatic void model_step();
        int nf;
        bit all;
        case (m_state)
            0: if (clear) m_zero();
               else if (start) begin
                   m_zero(); m_state = 1; m_lim = longint'(tmo); m_cyc = 0;
               end
            1: if (clear) begin
                   m_zero(); m_state = 0;
               end else begin
                   nf = -1;
                   for (int i = 0; i < N; i++) begin
                       if (eoc[i] && !m_eoc[i]) begin
                           m_eoc[i]  = 1;
                           m_code[i] = code[i];
                           if (code[i] != 0) begin
                               m_fail[i] = 1;
                               if (nf < 0) nf = i;
                           end
                       end
                   end
                   if (!m_ffvld && nf >= 0) begin m_ffvld = 1; m_ffid = nf; end
                   all = 1;
                   for (int i = 0; i < N; i++) if (!m_eoc[i]) all = 0;
                   if (all) begin
                       m_state = 2;
                       m_exit  = m_ffvld ? m_code[m_ffid] : '0;
                   end else if (TMO_ON && m_lim != 0 && m_cyc >= m_lim) begin
                       m_state = 2; m_tmo = 1; m_exit = '1;
                   end
                   m_cyc++;
               end
            default: if (clear) begin m_zero(); m_state = 0; end
        endcase
    endfunction

    initial begin
        m_state = 0; m_zero();
        forever begin
            @(negedge rst_n);
            m_state = 0; m_zero();
        end
    end

    initial forever begin
        @(posedge clk);
        if (rst_n) model_step();
    end

    // Single compare process: every cycle out of reset, away from the edge.
    initial forever begin
        logic [N-1:0] em, fm;
        @(negedge clk);
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin em[i] = m_eoc[i]; fm[i] = m_fail[i]; end
            chk("m_busy",   64'(busy),      64'(m_state == 1));
            chk("m_done",   64'(done),      64'(m_state == 2));
            chk("m_fetch",  64'(fetch_en),  (m_state == 1) ? 64'hF : 64'h0);
            chk("m_eocm",   64'(eoc_mask),  64'(em));
            chk("m_failm",  64'(fail_mask), 64'(fm));
            chk("m_ffvld",  64'(ff_vld),    64'(m_ffvld));
            chk("m_ffid",   64'(ff_id),     64'(m_ffid));
            chk("m_exit",   64'(exit_code), 64'(m_exit));
            chk("m_tmo",    64'(timeout),   64'(m_tmo));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic do_clear();
        eoc = '0; code = '0;
        clear = 1'b1; tick(1); clear = 1'b0; tick(1);
    endtask

    task automatic wait_done(input string nm, input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin tick(1); k++; end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s: done not seen within %0d cycles", nm, budget);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int k;
        // Reset state
        #2 rst_n = 1'b0;
        #3;
        chk("rst_busy",  64'(busy), 0);
        chk("rst_done",  64'(done), 0);
        chk("rst_fetch", 64'(fetch_en), 0);
        chk("rst_exit",  64'(exit_code), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick(2);

        // 1: all tiles pass, EOC at 10/20/30/40
        pulse_start();
        chk("t1_busy",  64'(busy), 1);
        chk("t1_fetch", 64'(fetch_en), 64'hF);
        tick(9);  eoc[0] = 1'b1;
        tick(10); eoc[1] = 1'b1;
        tick(10); eoc[2] = 1'b1;
        tick(10);
        chk("t1_not_done", 64'(done), 0);
        eoc[3] = 1'b1;
        tick(1);
        chk("t1_done",  64'(done), 1);
        chk("t1_exit",  64'(exit_code), 0);
        chk("t1_failm", 64'(fail_mask), 0);
        chk("t1_fetch0",64'(fetch_en), 0);
        pulse_start();
        chk("t1_start_in_done", 64'(done), 1);
        do_clear();
        chk("t1_cleared", 64'(done), 0);

        // 2: tiles 1 and 3 fail together
        pulse_start();
        tick(3);
        code[1] = 32'd5; code[3] = 32'd7; eoc[1] = 1'b1; eoc[3] = 1'b1;
        tick(4);
        eoc[0] = 1'b1; eoc[2] = 1'b1;
        wait_done("t2_wait", 10);
        chk("t2_failm", 64'(fail_mask), 64'b1010);
        chk("t2_ffid",  64'(ff_id), 1);
        chk("t2_exit",  64'(exit_code), 5);
        do_clear();

        // 3: tile 2 fails first, tile 0 later, tile 2 code changes afterwards
        pulse_start();
        tick(4); code[2] = 32'd9; eoc[2] = 1'b1;
        tick(3); code[0] = 32'd3; eoc[0] = 1'b1;
        tick(2); code[2] = 32'd4; eoc[2] = 1'b0;
        tick(2); eoc[2] = 1'b1; eoc[1] = 1'b1; eoc[3] = 1'b1;
        wait_done("t3_wait", 10);
        chk("t3_ffid",  64'(ff_id), 2);
        chk("t3_exit",  64'(exit_code), 9);
        chk("t3_failm", 64'(fail_mask), 64'b0101);
        do_clear();

        // 4: watchdog, limit 50, one tile never finishes
        tmo = 32'd50;
        pulse_start();
        tmo = 32'd5;
        eoc = 4'b0111;
        k = 0;
        while (!done && k < 60) begin tick(1); k++; end
`ifdef MAGIA_EOC_TIMEOUT_EN
        chk("t4_edges", 64'(k), 51);
        chk("t4_tmo",   64'(timeout), 1);
        chk("t4_exit",  64'(exit_code), 64'hFFFF_FFFF);
`else
        chk("t4_off_done", 64'(done), 0);
        chk("t4_off_busy", 64'(busy), 1);
`endif
        do_clear();

        // 5: last EOC in the exact timeout cycle
        tmo = 32'd20;
        pulse_start();
        eoc = 4'b0111;
        tick(20);
        chk("t5_not_done", 64'(done), 0);
        eoc[3] = 1'b1;
        tick(1);
        chk("t5_done", 64'(done), 1);
        chk("t5_tmo",  64'(timeout), 0);
        chk("t5_exit", 64'(exit_code), 0);
        tmo = '0;
        do_clear();

        // 6: restart ignored, clear beats start, async reset mid-run
        pulse_start();
        tick(2); code[0] = 32'd6; eoc[0] = 1'b1;
        tick(1);
        start = 1'b1; tick(1); start = 1'b0;
        chk("t6_busy", 64'(busy), 1);
        chk("t6_fail_pre", 64'(fail_mask), 64'b0001);
        clear = 1'b1; start = 1'b1; tick(1); clear = 1'b0; start = 1'b0;
        chk("t6_clr_busy",  64'(busy), 0);
        chk("t6_clr_eocm",  64'(eoc_mask), 0);
        chk("t6_clr_ffvld", 64'(ff_vld), 0);
        eoc = '0; code = '0;
        tick(2);
        pulse_start();
        tick(4); code[1] = 32'd3; eoc[1] = 1'b1;
        tick(10);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy",  64'(busy), 0);
        chk("t6_rst_fetch", 64'(fetch_en), 0);
        chk("t6_rst_eocm",  64'(eoc_mask), 0);
        chk("t6_rst_failm", 64'(fail_mask), 0);
        chk("t6_rst_ffvld", 64'(ff_vld), 0);
        tick(2);
        eoc = '0; code = '0;
        rst_n = 1'b1;
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
